fused_tensor_streamer: RTL and testbench

- Downstream stage of the fusion top level: consumes the 2048-bit fused tensor, its valid level and its 8-bit error flags.
- Serialises each tensor into a framed 16-bit word stream with valid/ready handshake: header, 128 data words, checksum.
- Two-slot tensor buffer absorbs back-pressure from the consumer; tensors arriving while both slots are full are dropped and counted.

---
 rtl/fused_tensor_streamer.sv | 171 +++++++++++++++++
 tb/tb_fused_tensor_streamer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fused_tensor_streamer.sv
// Fused tensor streamer: buffers up to two tensors and serialises each
// into a framed word stream (header, data words, checksum).
module fused_tensor_streamer #(
  parameter int TENSOR_WIDTH = 2048,
  parameter int WORD_WIDTH   = 16,
  parameter int NUM_WORDS    = TENSOR_WIDTH / WORD_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TENSOR_WIDTH-1:0] tensor_in,
  input  logic                    tensor_valid,
  input  logic [7:0]              tensor_err,
  input  logic                    clear_stats,
  output logic [WORD_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic [1:0]              buf_count,
  output logic                    overflow,
  output logic [7:0]              drop_count
);

  localparam int IW = $clog2(NUM_WORDS);
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA,
    CHECKSUM
  } state_t;

  state_t state, state_nx;

  logic [TENSOR_WIDTH-1:0] slot_data [2];
  logic [7:0]              slot_err  [2];

  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  tv_q;
  logic [7:0]            seq;
  logic [IW-1:0]         idx;
  logic [WORD_WIDTH-1:0] sum;

  logic                  xfer;
  logic                  rise;
  logic                  rel;
  logic                  slot_free;
  logic                  capture;
  logic                  drop;
  logic [WORD_WIDTH-1:0] hdr_word;
  logic [WORD_WIDTH-1:0] data_word;

  assign xfer      = out_valid & out_ready;
  assign rise      = tensor_valid & ~tv_q;
  assign rel       = xfer & (state == CHECKSUM);
  // A checksum leaving this cycle frees its slot for a same-edge capture.
  assign slot_free = (buf_count != 2'd2) | rel;
  assign capture   = rise & slot_free;
  assign drop      = rise & ~slot_free;

  assign hdr_word  = WORD_WIDTH'({seq, slot_err[rd_ptr]});
  assign data_word = slot_data[rd_ptr][idx*WORD_WIDTH +: WORD_WIDTH];

  always_comb begin
    state_nx  = state;
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_data  = '0;
    unique case (state)
      IDLE: begin
        if (buf_count != 2'd0)
          state_nx = HEADER;
      end
      HEADER: begin
        out_valid = 1'b1;
        out_sop   = 1'b1;
        out_data  = hdr_word;
        if (out_ready)
          state_nx = DATA;
      end
      DATA: begin
        out_valid = 1'b1;
        out_data  = data_word;
        if (out_ready && idx == LAST)
          state_nx = CHECKSUM;
      end
      CHECKSUM: begin
        out_valid = 1'b1;
        out_eop   = 1'b1;
        out_data  = sum;
        if (out_ready) begin
          if (buf_count == 2'd2 || capture)
            state_nx = HEADER;
          else
            state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tv_q      <= 1'b0;
      buf_count <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      seq       <= 8'd0;
    end else begin
      tv_q <= tensor_valid;
      if (capture && !rel)
        buf_count <= buf_count + 2'd1;
      else if (rel && !capture)
        buf_count <= buf_count - 2'd1;
      if (capture)
        wr_ptr <= ~wr_ptr;
      if (rel) begin
        rd_ptr <= ~rd_ptr;
        seq    <= seq + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      sum <= '0;
    end else if (xfer) begin
      if (state == HEADER) begin
        idx <= '0;
        sum <= hdr_word;
      end else if (state == DATA) begin
        idx <= idx + 1'b1;
        sum <= sum + data_word;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (clear_stats) begin
      overflow   <= drop;
      drop_count <= {7'd0, drop};
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end
  end

  // Slot storage needs no reset; occupancy is tracked by buf_count.
  always_ff @(posedge clk) begin
    if (capture) begin
      slot_data[wr_ptr] <= tensor_in;
      slot_err[wr_ptr]  <= tensor_err;
    end
  end

endmodule

// File: tb/tb_fused_tensor_streamer.sv
// Bench for fused_tensor_streamer: random and directed stimulus
// checked against a frame-queue reference model.
module tb_fused_tensor_streamer;

  localparam int TW = 2048;
  localparam int WW = 16;
  localparam int NW = TW / WW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [TW-1:0] tensor_in = '0;
  logic          tensor_valid = 1'b0;
  logic [7:0]    tensor_err = 8'd0;
  logic          clear_stats = 1'b0;
  logic [WW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_sop;
  logic          out_eop;
  logic [1:0]    buf_count;
  logic          overflow;
  logic [7:0]    drop_count;

  fused_tensor_streamer #(
    .TENSOR_WIDTH(TW),
    .WORD_WIDTH(WW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tensor_in(tensor_in),
    .tensor_valid(tensor_valid),
    .tensor_err(tensor_err),
    .clear_stats(clear_stats),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sop(out_sop),
    .out_eop(out_eop),
    .buf_count(buf_count),
    .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] t;
    logic [7:0]    e;
  } frame_t;

  frame_t     mq[$];
  logic [7:0] hs[$];
  int         pos;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         frames = 0;
  int         gaps = 0;
  bit         gap_on = 0;
  int         words_in_frame = 0;
  int         last_frame_words = 0;
  logic [15:0] last_ck;
  logic [7:0] mseq;
  logic [7:0] mdc;
  logic       mov;
  logic       mtv;
  logic       stall_q;
  logic [WW+1:0] prev_o;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_word(frame_t f, int p,
                                           logic [7:0] s);
    logic [15:0] acc;
    if (p == 0)
      return {s, f.e};
    if (p <= NW)
      return f.t[(p-1)*WW +: WW];
    acc = {s, f.e};
    for (int k = 0; k < NW; k++)
      acc += f.t[k*WW +: WW];
    return acc;
  endfunction

  task automatic tick();
    bit     rel;
    bit     rise;
    bit     free;
    frame_t nf;
    if (stall_q) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_hold", {out_sop, out_eop, out_data}, prev_o);
    end
    if (out_valid)
      chk("valid_pending", mq.size() != 0, 1);
    if (gap_on && mq.size() != 0 && !out_valid)
      gaps++;
    rel = 0;
    if (out_valid && out_ready) begin
      if (mq.size() == 0) begin
        chk("spurious_xfer", mq.size(), 1);
      end else begin
        chk("word", out_data, exp_word(mq[0], pos, mseq));
        chk("sop", out_sop, pos == 0);
        chk("eop", out_eop, pos == NW + 1);
        if (pos == 0) begin
          hs.push_back(out_data[15:8]);
          words_in_frame = 0;
        end
        words_in_frame++;
        pos++;
        if (pos == NW + 2) begin
          last_ck = out_data;
          last_frame_words = words_in_frame;
          void'(mq.pop_front());
          pos = 0;
          mseq++;
          frames++;
          rel = 1;
        end
      end
    end
    stall_q = out_valid && !out_ready;
    prev_o = {out_sop, out_eop, out_data};
    rise = tensor_valid && !mtv;
    free = mq.size() < 2;
    if (rise && free) begin
      nf.t = tensor_in;
      nf.e = tensor_err;
      mq.push_back(nf);
    end
    if (clear_stats) begin
      mov = rise && !free;
      mdc = (rise && !free) ? 8'd1 : 8'd0;
    end else if (rise && !free) begin
      mov = 1;
      if (mdc != 8'hFF)
        mdc++;
    end
    mtv = tensor_valid;
    @(posedge clk);
    #1;
    chk("buf_count", buf_count, mq.size());
    chk("overflow", overflow, mov);
    chk("drop_count", drop_count, mdc);
    if (rel)
      chk("rel_seen", frames != 0, 1);
  endtask

  task automatic do_reset();
    tensor_valid = 0;
    clear_stats = 0;
    #2;
    rst = 1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_buf", buf_count, 0);
    chk("rst_sop_eop", {out_sop, out_eop}, 0);
    chk("rst_data", out_data, 0);
    chk("rst_stats", {overflow, drop_count}, 0);
    @(posedge clk);
    #1;
    rst = 0;
    mq.delete();
    pos = 0;
    mseq = 0;
    mov = 0;
    mdc = 0;
    mtv = 0;
    stall_q = 0;
  endtask

  task automatic drain(bit rnd, int lim);
    int n = 0;
    while (mq.size() != 0 && n < lim) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    chk("drain_timeout", mq.size(), 0);
  endtask

  task automatic rand_tensor();
    for (int i = 0; i < TW / 32; i++)
      tensor_in[i*32 +: 32] = $urandom;
    tensor_err = 8'($urandom);
  endtask

  task automatic one_capture();
    tensor_valid = 1;
    tick();
    tensor_valid = 0;
    tick();
  endtask

  initial begin
    int f0;
    int n;
    pos = 0;
    mseq = 0;
    mdc = 0;
    mov = 0;
    mtv = 0;
    stall_q = 0;
    do_reset();

    // single frame with counting pattern
    for (int k = 0; k < NW; k++)
      tensor_in[k*WW +: WW] = 16'(k + 1);
    tensor_err = 8'h03;
    out_ready = 1;
    tensor_valid = 1;
    tick();
    tick();
    chk("lat_valid", out_valid, 1);
    chk("lat_header", out_data, 16'h0003);
    tensor_valid = 0;
    drain(0, 400);
    chk("single_ck", last_ck, 16'h2043);
    chk("single_words", last_frame_words, NW + 2);
    chk("single_idle", out_valid, 0);

    // same frame under random back-pressure
    f0 = frames;
    out_ready = 0;
    one_capture();
    drain(1, 2000);
    chk("bp_frames", frames - f0, 1);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rand_tensor();
      if ($urandom_range(0, 29) == 0)
        tensor_valid = ~tensor_valid;
      out_ready = ($urandom_range(0, 9) < 7);
      clear_stats = ($urandom_range(0, 199) == 0);
      tick();
    end
    clear_stats = 0;
    tensor_valid = 0;
    drain(0, 1000);

    // overflow from a fresh reset
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      rand_tensor();
      one_capture();
    end
    chk("ovf_buf", buf_count, 2);
    chk("ovf_flag", overflow, 1);
    chk("ovf_cnt", drop_count, 1);
    hs.delete();
    f0 = frames;
    gaps = 0;
    gap_on = 1;
    drain(0, 1000);
    gap_on = 0;
    chk("ovf_frames", frames - f0, 2);
    chk("ovf_no_bubble", gaps, 0);
    chk("ovf_seq0", hs.size() > 0 ? hs[0] : 8'hEE, 0);
    chk("ovf_seq1", hs.size() > 1 ? hs[1] : 8'hEE, 1);

    // level hold
    clear_stats = 1;
    tick();
    clear_stats = 0;
    f0 = frames;
    out_ready = 1;
    rand_tensor();
    tensor_valid = 1;
    repeat (500) tick();
    tensor_valid = 0;
    tick();
    drain(0, 400);
    chk("hold_frames", frames - f0, 1);
    chk("hold_drops", drop_count, 0);

    // capture aligned with a checksum transfer while full
    out_ready = 0;
    rand_tensor();
    one_capture();
    rand_tensor();
    one_capture();
    chk("sc_full", buf_count, 2);
    out_ready = 1;
    n = 0;
    while (!(pos == NW + 1 && mq.size() == 2) && n < 400) begin
      tick();
      n++;
    end
    chk("sc_reach", pos, NW + 1);
    rand_tensor();
    tensor_valid = 1;
    f0 = frames;
    tick();
    tensor_valid = 0;
    chk("sc_buf", buf_count, 2);
    chk("sc_drop", drop_count, 0);
    chk("sc_ovf", overflow, 0);
    drain(0, 1000);
    chk("sc_frames", frames - f0, 3);

    // reset in the middle of a frame
    chk("pre_seq_nonzero", mseq != 0, 1);
    rand_tensor();
    tensor_valid = 1;
    tick();
    tensor_valid = 0;
    n = 0;
    while (pos != 61 && n < 400) begin
      tick();
      n++;
    end
    chk("mid_reach", pos, 61);
    do_reset();
    hs.delete();
    rand_tensor();
    one_capture();
    drain(0, 400);
    chk("mid_seq", hs.size() > 0 ? hs[0] : 8'hEE, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
